// File: rtl/clk_div_monitor_pkg.sv
// clk_div_monitor_pkg
// Shared definitions for the divided-clock monitor and the divider bench:
// the measurement FSM state type and the default parameter values.
package clk_div_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } mon_state_t;

    localparam int DEFAULT_CNT_W       = 16;
    localparam int DEFAULT_NUM_PERIODS = 4;
    localparam int DEFAULT_TIMEOUT     = 1024;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_div_edge_sync.sv
// clk_div_edge_sync
// Samples the divided clock as ordinary data through a SYNC_STAGES flop
// chain, keeps one extra flop of history and flags rising edges.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   din    in  divided clock under test
//   level  out synchronised level (s)
//   rise   out one-cycle flag: level is 1 and was 0 on the previous cycle
module clk_div_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // Shift the raw input through the chain; the last stage is the usable
    // level and level_d is its one-cycle history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Measures the rising-edge period and high time of a divided clock, in clk
// cycles, over NUM_PERIODS periods and compares the period against the
// programmed divide ratio latched at start.
// Ports:
//   clk        in  system clock (also the divider's source)
//   rst_n      in  asynchronous active-low reset
//   div_clk    in  divided clock under test, sampled as data
//   div        in  programmed divide ratio
//   start      in  one-cycle measurement request (ignored while busy)
//   busy       out measurement in progress
//   done       out one-cycle pulse; results are valid while it is high
//   period_sum out clk cycles spanning NUM_PERIODS rising-edge periods
//   high_sum   out cycles the sampled div_clk was high in that window
//   mismatch   out period_sum differs from div*NUM_PERIODS, or timeout
//   timeout    out no rising edge seen for TIMEOUT cycles
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int NUM_PERIODS = DEFAULT_NUM_PERIODS,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic [7:0]       div,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_sum,
    output logic [CNT_W-1:0] high_sum,
    output logic             mismatch,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] NP_C      = CNT_W'(NUM_PERIODS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        return wide[CNT_W] ? {CNT_W{1'b1}} : wide[CNT_W-1:0];
    endfunction

    logic s;
    logic rise;

    clk_div_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (div_clk),
        .level(s),
        .rise (rise)
    );

    mon_state_t       state, state_next;
    logic [7:0]       div_latched, div_latched_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] edges, edges_n;
    logic [CNT_W-1:0] period_acc, period_acc_n;
    logic [CNT_W-1:0] high_acc, high_acc_n;
    logic [CNT_W-1:0] period_sum_n, high_sum_n;
    logic             timeout_n, mismatch_n;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] expected_period;
    logic             last_edge;

    assign cnt_inc         = sat_inc(cnt);
    assign expected_period = CNT_W'(div_latched) * NP_C;
    assign last_edge       = (edges + ONE) == NP_C;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers; all next values come from the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_latched <= '0;
            cnt         <= '0;
            edges       <= '0;
            period_acc  <= '0;
            high_acc    <= '0;
            period_sum  <= '0;
            high_sum    <= '0;
            timeout     <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            div_latched <= div_latched_n;
            cnt         <= cnt_n;
            edges       <= edges_n;
            period_acc  <= period_acc_n;
            high_acc    <= high_acc_n;
            period_sum  <= period_sum_n;
            high_sum    <= high_sum_n;
            timeout     <= timeout_n;
            mismatch    <= mismatch_n;
        end
    end

    // Next-state and datapath logic. The high count uses the synchronised
    // level s, which is 1 on every rise cycle, so a period's own rise is
    // counted and only the terminating rise is skipped. Results are loaded
    // on the edge that enters DONE so they are already valid while done=1.
    always_comb begin
        state_next    = state;
        div_latched_n = div_latched;
        cnt_n         = cnt;
        edges_n       = edges;
        period_acc_n  = period_acc;
        high_acc_n    = high_acc;
        period_sum_n  = period_sum;
        high_sum_n    = high_sum;
        timeout_n     = timeout;
        mismatch_n    = mismatch;
        busy          = (state != IDLE);
        done          = (state == DONE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = ARM;
                    div_latched_n = div;
                    cnt_n         = '0;
                    edges_n       = '0;
                    period_acc_n  = '0;
                    high_acc_n    = '0;
                    timeout_n     = 1'b0;
                    mismatch_n    = 1'b0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_next = MEAS;
                    cnt_n      = ONE;
                    high_acc_n = sat_inc(high_acc);
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= TIMEOUT_C) begin
                        state_next = DONE;
                        timeout_n  = 1'b1;
                    end
                end
            end
            MEAS: begin
                if (rise) begin
                    period_acc_n = sat_add(period_acc, cnt);
                    cnt_n        = ONE;
                    edges_n      = sat_inc(edges);
                    if (last_edge) begin
                        state_next = DONE;
                    end else begin
                        high_acc_n = sat_inc(high_acc);
                    end
                end else begin
                    cnt_n = cnt_inc;
                    if (s) begin
                        high_acc_n = sat_inc(high_acc);
                    end
                    if (cnt_inc >= TIMEOUT_C) begin
                        state_next = DONE;
                        timeout_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state != DONE && state_next == DONE) begin
            period_sum_n = period_acc_n;
            high_sum_n   = high_acc_n;
            mismatch_n   = timeout_n | (period_acc_n != expected_period);
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
// Self-checking bench: a behavioural divider drives div_clk from clk and
// the expected results come from the divide ratio itself (period = ratio,
// high time = ratio/2 cycles per period for this divider).
module tb_clk_div_monitor;

    localparam int CNT_W = 16;
    localparam int NP    = 4;
    localparam int TO    = 1024;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             div_clk;
    logic [7:0]       div = 8'd0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period_sum;
    logic [CNT_W-1:0] high_sum;
    logic             mismatch;
    logic             timeout;

    int errors = 0;
    int checks = 0;
    int div_ratio = 0;
    int phase = 0;

    always #5 clk = ~clk;

    // Behavioural divider: ratio r gives a period of r clk cycles, high for
    // the first r/2 of them; ratios below 2 hold the output low.
    initial begin
        div_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (div_ratio < 2) begin
                div_clk = 1'b0;
                phase   = 0;
            end else begin
                phase   = (phase + 1) % div_ratio;
                div_clk = (phase < div_ratio / 2);
            end
        end
    end

    clk_div_monitor #(
        .CNT_W      (CNT_W),
        .NUM_PERIODS(NP),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_clk   (div_clk),
        .div       (div),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .period_sum(period_sum),
        .high_sum  (high_sum),
        .mismatch  (mismatch),
        .timeout   (timeout)
    );

    // Reference model from the measurement rules and the divider ratio.
    function automatic void model(input int ratio, input int d,
                                  output int p, output int h,
                                  output bit to, output bit mm);
        if (ratio < 2) begin
            p = 0; h = 0; to = 1'b1; mm = 1'b1;
        end else begin
            p  = ratio * NP;
            if (p > 65535) p = 65535;
            h  = (ratio / 2) * NP;
            to = 1'b0;
            mm = (p != ((d * NP) % 65536));
        end
    endfunction

    task automatic set_ratio(input int r);
        div_ratio = r;
        repeat (40) @(negedge clk);
    endtask

    task automatic start_measurement(input logic [7:0] d);
        @(negedge clk);
        div   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; cycles counts negedges
    // since the start edge (the first one after start is 1).
    task automatic wait_for_done(input int budget, output int cycles, output bit found);
        cycles = 1;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        found = (done === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("[TB] FAIL reset_mismatch: got %0b expected 0", mismatch); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %0b expected 0", timeout); end
        checks++; if (period_sum !== '0) begin errors++; $display("[TB] FAIL reset_period: got %0d expected 0", period_sum); end
        checks++; if (high_sum !== '0) begin errors++; $display("[TB] FAIL reset_high: got %0d expected 0", high_sum); end
        rst_n = 1'b1;
    endtask

    task automatic test_ratio4();
        int c; bit f;
        set_ratio(4);
        start_measurement(8'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL r4_busy_after_start: got %0b expected 1", busy); end
        wait_for_done(200, c, f);
        checks++; if (!f) begin errors++; $display("[TB] FAIL r4_done: got 0 expected 1 within 200 cycles"); end
        checks++; if (int'(period_sum) !== 16) begin errors++; $display("[TB] FAIL r4_period: got %0d expected 16", period_sum); end
        checks++; if (int'(high_sum) !== 8) begin errors++; $display("[TB] FAIL r4_high: got %0d expected 8", high_sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("[TB] FAIL r4_mismatch: got %0b expected 0", mismatch); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL r4_timeout: got %0b expected 0", timeout); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL r4_busy_in_done: got %0b expected 1", busy); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL r4_after_done: got done,busy=%02b expected 00", {done, busy}); end
    endtask

    task automatic test_ratio5();
        int c; bit f;
        set_ratio(5);
        start_measurement(8'd5);
        wait_for_done(200, c, f);
        checks++; if (!f) begin errors++; $display("[TB] FAIL r5_done: got 0 expected 1 within 200 cycles"); end
        checks++; if (int'(period_sum) !== 20) begin errors++; $display("[TB] FAIL r5_period: got %0d expected 20", period_sum); end
        checks++; if (high_sum < 8 || high_sum > 12) begin errors++; $display("[TB] FAIL r5_high: got %0d expected 8..12", high_sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("[TB] FAIL r5_mismatch: got %0b expected 0", mismatch); end
    endtask

    task automatic test_wrong_div();
        int c; bit f;
        set_ratio(4);
        start_measurement(8'd6);
        wait_for_done(200, c, f);
        checks++; if (!f) begin errors++; $display("[TB] FAIL wd_done: got 0 expected 1 within 200 cycles"); end
        checks++; if (int'(period_sum) !== 16) begin errors++; $display("[TB] FAIL wd_period: got %0d expected 16", period_sum); end
        checks++; if (mismatch !== 1'b1) begin errors++; $display("[TB] FAIL wd_mismatch: got %0b expected 1", mismatch); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_timeout: got %0b expected 0", timeout); end
    endtask

    task automatic test_timeout();
        int c; bit f;
        set_ratio(0);
        start_measurement(8'd4);
        wait_for_done(TO + 50, c, f);
        checks++; if (!f) begin errors++; $display("[TB] FAIL to_done: got 0 expected 1 within %0d cycles", TO + 50); end
        checks++; if (c !== TO + 1) begin errors++; $display("[TB] FAIL to_latency: got %0d expected %0d", c, TO + 1); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_timeout: got %0b expected 1", timeout); end
        checks++; if (mismatch !== 1'b1) begin errors++; $display("[TB] FAIL to_mismatch: got %0b expected 1", mismatch); end
        checks++; if (period_sum !== '0) begin errors++; $display("[TB] FAIL to_period: got %0d expected 0", period_sum); end
        checks++; if (high_sum !== '0) begin errors++; $display("[TB] FAIL to_high: got %0d expected 0", high_sum); end
    endtask

    task automatic test_back_to_back();
        int c; bit f; int extra_done;
        set_ratio(4);
        start_measurement(8'd4);
        repeat (4) @(negedge clk);
        div   = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for_done(200, c, f);
        checks++; if (!f) begin errors++; $display("[TB] FAIL b2b_done: got 0 expected 1 within 200 cycles"); end
        checks++; if (int'(period_sum) !== 16) begin errors++; $display("[TB] FAIL b2b_period: got %0d expected 16", period_sum); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mismatch: got %0b expected 0", mismatch); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        checks++; if (extra_done !== 0) begin errors++; $display("[TB] FAIL b2b_ignored_start: got %0d busy/done cycles expected 0", extra_done); end
    endtask

    task automatic test_reset_mid();
        int c; bit f; int seen_done;
        set_ratio(4);
        start_measurement(8'd4);
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_busy_before: got %0b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy: got %0b expected 0", busy); end
        checks++; if ({done, mismatch, timeout} !== 3'b000) begin errors++; $display("[TB] FAIL rm_flags: got %03b expected 000", {done, mismatch, timeout}); end
        checks++; if (period_sum !== '0 || high_sum !== '0) begin errors++; $display("[TB] FAIL rm_sums: got %0d/%0d expected 0/0", period_sum, high_sum); end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("[TB] FAIL rm_no_done: got %0d pulses expected 0", seen_done); end
        start_measurement(8'd4);
        wait_for_done(200, c, f);
        checks++; if (!f) begin errors++; $display("[TB] FAIL rm_restart_done: got 0 expected 1 within 200 cycles"); end
        checks++; if (int'(period_sum) !== 16 || mismatch !== 1'b0) begin errors++; $display("[TB] FAIL rm_restart: got period %0d mismatch %0b expected 16 0", period_sum, mismatch); end
    endtask

    task automatic test_random();
        int c; bit f; int r; int d; int ep; int eh; bit eto; bit emm;
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(2, 24);
            d = ($urandom_range(0, 1) == 1) ? r : $urandom_range(0, 30);
            set_ratio(r);
            model(r, d, ep, eh, eto, emm);
            start_measurement(8'(d));
            wait_for_done(TO + r * (NP + 2) + 20, c, f);
            checks++; if (!f) begin errors++; $display("[TB] FAIL rnd_done r=%0d: got 0 expected 1", r); end
            checks++; if (int'(period_sum) !== ep) begin errors++; $display("[TB] FAIL rnd_period r=%0d: got %0d expected %0d", r, period_sum, ep); end
            checks++;
            if ((r % 2 == 0 && int'(high_sum) !== eh) ||
                (r % 2 == 1 && (2 * int'(high_sum) < r * NP - 2 * NP || 2 * int'(high_sum) > r * NP + 2 * NP))) begin
                errors++; $display("[TB] FAIL rnd_high r=%0d: got %0d expected about %0d", r, high_sum, eh);
            end
            checks++; if ({timeout, mismatch} !== {eto, emm}) begin errors++; $display("[TB] FAIL rnd_flags r=%0d d=%0d: got to,mm=%02b expected %02b", r, d, {timeout, mismatch}, {eto, emm}); end
        end
    endtask

    initial begin
        test_reset();
        test_ratio4();
        test_ratio5();
        test_wrong_div();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
